// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a first-word-fall-through receive FIFO
// and sticky error flags (overrun, framing, parity, break).
// Optional build macro UART_RX_BREAK_EN: when defined, a frame whose data,
// parity and stop bits all sample 0 sets break_det instead of frame_err.
module uart_rx_fifo #(
    parameter int CLK_CYCLES = 87,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  rd_en,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun_err,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  break_det,
    input  logic                  clear_err
);

    localparam int                TW       = $clog2(CLK_CYCLES);
    localparam logic [TW-1:0]     T_LAST   = TW'(CLK_CYCLES - 1);
    localparam logic [TW-1:0]     T_HALF   = TW'(CLK_CYCLES / 2);
    localparam logic [3:0]        B_LAST   = 4'(DATA_BITS - 1);
    localparam int                DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        PAR_BIT,
        STOP
    } state_t;

    state_t                 state;
    logic [TW-1:0]          timer;
    logic [3:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bit;
    logic                   tick;
    logic                   par_ok;
    logic                   push;
    logic                   do_push;
    logic                   do_pop;

    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;

    // Sample strobe, parity check and FIFO push/pop qualification
    always_comb begin
        tick   = (timer == T_LAST);
        par_ok = 1'b1;
        if (PARITY != 0) begin
            par_ok = (par_bit == ((^shift) ^ (PARITY == 1)));
        end
        push    = (state == STOP) && tick && uart_rx && par_ok;
        do_pop  = rd_en && (count != '0);
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push = push && ((count != FULL_CNT) || do_pop);
    end

    // Receive FSM: bit timing, shift register and line-error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_HIGH;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_BREAK_EN
            break_det  <= 1'b0;
`endif
        end else begin
            // clear first; an error event below in the same cycle wins
            frame_err  <= frame_err & ~clear_err;
            parity_err <= parity_err & ~clear_err;
`ifdef UART_RX_BREAK_EN
            break_det  <= break_det & ~clear_err;
`endif
            case (state)
                WAIT_HIGH: begin
                    if (uart_rx) state <= IDLE;
                end
                IDLE: begin
                    if (!uart_rx) begin
                        state <= START;
                        timer <= '0;
                    end
                end
                START: begin
                    if (timer == T_HALF) begin
                        timer <= '0;
                        if (uart_rx) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        timer <= '0;
                        shift <= {uart_rx, shift[DATA_BITS-1:1]};
                        if (bit_idx == B_LAST) begin
                            state <= (PARITY != 0) ? PAR_BIT : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PAR_BIT: begin
                    if (tick) begin
                        timer   <= '0;
                        par_bit <= uart_rx;
                        state   <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        timer <= '0;
                        if (uart_rx) begin
                            if (!par_ok) parity_err <= 1'b1;
                            state <= IDLE;
                        end else begin
`ifdef UART_RX_BREAK_EN
                            if ((shift == '0) && !par_bit) break_det <= 1'b1;
                            else                           frame_err <= 1'b1;
`else
                            frame_err <= 1'b1;
`endif
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

`ifndef UART_RX_BREAK_EN
    assign break_det = 1'b0;
`endif

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    // FIFO pointers, occupancy and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            overrun_err <= (overrun_err & ~clear_err) | (push & ~do_push);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into an 8N1 receiver (u0) and an 8E1
// receiver (u1); a frame-level model predicts FIFO contents and flags.
module tb_uart_rx_fifo;

    localparam int CLK  = 87;
    localparam int HALF = CLK / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1, rd0, rd1, clr0, clr1;
    logic [7:0] rdat0, rdat1;
    logic       em0, em1, fu0, fu1;
    logic [4:0] cn0, cn1;
    logic       ov0, ov1, fe0, fe1, pe0, pe1, bd0, bd1;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    bit m_ovr[2], m_fe[2], m_pe[2], m_bd[2];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_CYCLES(CLK), .DATA_BITS(8), .PARITY(0), .DEPTH_LOG2(4)) u0 (
        .clk(clk), .rst(rst), .uart_rx(rx0), .rd_en(rd0), .rd_data(rdat0),
        .empty(em0), .full(fu0), .count(cn0), .overrun_err(ov0),
        .frame_err(fe0), .parity_err(pe0), .break_det(bd0), .clear_err(clr0));

    uart_rx_fifo #(.CLK_CYCLES(CLK), .DATA_BITS(8), .PARITY(2), .DEPTH_LOG2(4)) u1 (
        .clk(clk), .rst(rst), .uart_rx(rx1), .rd_en(rd1), .rd_data(rdat1),
        .empty(em1), .full(fu1), .count(cn1), .overrun_err(ov1),
        .frame_err(fe1), .parity_err(pe1), .break_det(bd1), .clear_err(clr1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msize(input int s);
        return (s == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] mfront(input int s);
        return (s == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic model_pop(input int s);
        if (s == 0) begin
            if (mq0.size() > 0) void'(mq0.pop_front());
        end else begin
            if (mq1.size() > 0) void'(mq1.pop_front());
        end
    endtask

    task automatic model_clear(input int s);
        m_ovr[s] = 0; m_fe[s] = 0; m_pe[s] = 0; m_bd[s] = 0;
    endtask

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        model_clear(0); model_clear(1);
    endtask

    // Outcome of one received frame at its stop sample, from the line rules
    task automatic model_event(input int s, input logic [7:0] d, input logic pb,
                               input logic sb, input bit pop, input bit clr);
        bit has_par = (s == 1);
        bit brk     = 0;
        if (clr) model_clear(s);
        if (pop) model_pop(s);
`ifdef UART_RX_BREAK_EN
        brk = (d == 8'h00) && (!has_par || !pb);
`endif
        if (!sb) begin
            if (brk) m_bd[s] = 1;
            else     m_fe[s] = 1;
        end else if (has_par && (pb != (^d))) begin
            m_pe[s] = 1;
        end else if (msize(s) == 16) begin
            m_ovr[s] = 1;
        end else if (s == 0) begin
            mq0.push_back(d);
        end else begin
            mq1.push_back(d);
        end
    endtask

    task automatic cmp(input int s, input logic [7:0] rd, input logic em, input logic fu,
                       input logic [4:0] cn, input logic ov, input logic fe,
                       input logic pe, input logic bd);
        int n = msize(s);
        chk($sformatf("u%0d.count", s), 32'(cn), n);
        chk($sformatf("u%0d.empty", s), 32'(em), 32'(n == 0));
        chk($sformatf("u%0d.full", s), 32'(fu), 32'(n == 16));
        chk($sformatf("u%0d.overrun_err", s), 32'(ov), 32'(m_ovr[s]));
        chk($sformatf("u%0d.frame_err", s), 32'(fe), 32'(m_fe[s]));
        chk($sformatf("u%0d.parity_err", s), 32'(pe), 32'(m_pe[s]));
        chk($sformatf("u%0d.break_det", s), 32'(bd), 32'(m_bd[s]));
        if (n > 0) chk($sformatf("u%0d.rd_data", s), 32'(rd), 32'(mfront(s)));
    endtask

    // Per-cycle comparison of both receivers against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            cmp(0, rdat0, em0, fu0, cn0, ov0, fe0, pe0, bd0);
            cmp(1, rdat1, em1, fu1, cn1, ov1, fe1, pe1, bd1);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v);
        if (s == 0) rx0 = v;
        else        rx1 = v;
    endtask

    // One frame; the stop sample lands HALF+2 edges after the stop bit is driven
    task automatic send(input int s, input logic [7:0] d, input logic pb, input logic sb,
                        input bit pop_at, input bit clr_at);
        drive(s, 1'b0);
        wait_cyc(CLK);
        for (int i = 0; i < 8; i++) begin
            drive(s, d[i]);
            wait_cyc(CLK);
        end
        if (s == 1) begin
            drive(s, pb);
            wait_cyc(CLK);
        end
        drive(s, sb);
        wait_cyc(HALF + 1);
        if (pop_at) begin if (s == 0) rd0 = 1'b1; else rd1 = 1'b1; end
        if (clr_at) begin if (s == 0) clr0 = 1'b1; else clr1 = 1'b1; end
        wait_cyc(1);
        rd0 = 1'b0; rd1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        model_event(s, d, pb, sb, pop_at, clr_at);
        wait_cyc(CLK - HALF - 2);
    endtask

    task automatic pop(input int s);
        if (s == 0) rd0 = 1'b1; else rd1 = 1'b1;
        wait_cyc(1);
        rd0 = 1'b0; rd1 = 1'b0;
        model_pop(s);
    endtask

    task automatic clear_flags(input int s);
        if (s == 0) clr0 = 1'b1; else clr1 = 1'b1;
        wait_cyc(1);
        clr0 = 1'b0; clr1 = 1'b0;
        model_clear(s);
    endtask

    initial begin
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        rd0 = 1'b0; rd1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        model_reset();
        wait_cyc(3);
        rst = 1'b0;
        cmp_on = 1'b1;
        chk("reset empty", 32'(em0), 1);
        chk("reset count", 32'(cn0), 0);
        chk("reset full", 32'(fu0), 0);
        chk("reset flags", {28'd0, ov0, fe0, pe0, bd0}, 0);
        wait_cyc(10);

        // single byte, then pop
        send(0, 8'h41, 1'b0, 1'b1, 0, 0);
        chk("0x41 empty", 32'(em0), 0);
        chk("0x41 count", 32'(cn0), 1);
        chk("0x41 data", 32'(rdat0), 32'h41);
        pop(0);
        chk("0x41 popped empty", 32'(em0), 1);
        chk("0x41 popped count", 32'(cn0), 0);

        // short low glitch is rejected
        drive(0, 1'b0); wait_cyc(20); drive(0, 1'b1); wait_cyc(100);
        chk("glitch count", 32'(cn0), 0);
        chk("glitch flags", {29'd0, ov0, fe0, pe0}, 0);
        send(0, 8'h5A, 1'b0, 1'b1, 0, 0);
        chk("0x5A data", 32'(rdat0), 32'h5A);
        pop(0);

        // fill past capacity with back-to-back frames
        for (int i = 0; i < 17; i++) send(0, 8'(i), 1'b0, 1'b1, 0, 0);
        chk("fill full", 32'(fu0), 1);
        chk("fill count", 32'(cn0), 16);
        chk("fill overrun", 32'(ov0), 1);
        chk("fill head", 32'(rdat0), 32'h00);
        clear_flags(0);
        chk("overrun cleared", 32'(ov0), 0);

        // push while full with a pop in the same cycle: no overrun
        send(0, 8'h77, 1'b0, 1'b1, 1, 0);
        chk("full push+pop count", 32'(cn0), 16);
        chk("full push+pop overrun", 32'(ov0), 0);
        for (int i = 1; i < 16; i++) begin
            chk("drain order", 32'(rdat0), i);
            pop(0);
        end
        chk("drain last", 32'(rdat0), 32'h77);
        pop(0);
        pop(0);
        chk("pop on empty count", 32'(cn0), 0);

        // even parity: 0x07 needs parity bit 1
        send(1, 8'h07, 1'b0, 1'b1, 0, 0);
        chk("parity err set", 32'(pe1), 1);
        chk("parity err count", 32'(cn1), 0);
        clear_flags(1);
        chk("parity err cleared", 32'(pe1), 0);
        send(1, 8'h07, 1'b1, 1'b1, 0, 0);
        chk("parity ok data", 32'(rdat1), 32'h07);
        chk("parity ok count", 32'(cn1), 1);
        pop(1);

        // framing error, line low 3 bit times, recover, next byte
        send(0, 8'h55, 1'b0, 1'b0, 0, 0);
        wait_cyc(3 * CLK); drive(0, 1'b1); wait_cyc(2 * CLK);
        send(0, 8'hA5, 1'b0, 1'b1, 0, 0);
        chk("frame err set", 32'(fe0), 1);
        chk("frame err count", 32'(cn0), 1);
        chk("frame err data", 32'(rdat0), 32'hA5);
        pop(0);
        clear_flags(0);
        send(0, 8'h55, 1'b0, 1'b0, 0, 1);
        chk("frame err vs clear", 32'(fe0), 1);
        wait_cyc(3 * CLK); drive(0, 1'b1); wait_cyc(2 * CLK);
        clear_flags(0);

        // line low for 20 bit periods
        send(0, 8'h00, 1'b0, 1'b0, 0, 0);
        wait_cyc(10 * CLK); drive(0, 1'b1); wait_cyc(2 * CLK);
`ifdef UART_RX_BREAK_EN
        chk("break det", 32'(bd0), 1);
        chk("break frame_err", 32'(fe0), 0);
`else
        chk("break det", 32'(bd0), 0);
        chk("break frame_err", 32'(fe0), 1);
`endif
        chk("break count", 32'(cn0), 0);
        clear_flags(0);

        // reset mid-data-bit with the line low
        send(0, 8'h11, 1'b0, 1'b1, 0, 0);
        drive(0, 1'b0);
        wait_cyc(CLK + 40);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        model_reset();
        chk("mid reset count", 32'(cn0), 0);
        wait_cyc(300);
        chk("low after reset count", 32'(cn0), 0);
        chk("low after reset flags", {29'd0, ov0, fe0, pe0}, 0);
        drive(0, 1'b1); wait_cyc(100);
        send(0, 8'h3C, 1'b0, 1'b1, 0, 0);
        chk("after reset data", 32'(rdat0), 32'h3C);
        chk("after reset count", 32'(cn0), 1);
        wait_cyc(5);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the board-level UART receive path.
- Receives asynchronous serial frames with configurable data width, parity mode and bit period.
- Buffers received words in an internal first-word-fall-through FIFO.
- Reports sticky framing, parity and overrun errors.
- Sits between the synchronised RsRx pin and any consumer (display counter, command decoder); replaces the single-byte receive/strobe interface.

Parameters:
- CLK_CYCLES, 87: clk cycles per bit period (115200 baud at 10 MHz); minimum 4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- uart_rx  in  1  serial line, already 2-flop synchronised to clk; idles high
- rd_en  in  1  pop head word; ignored when empty
- rd_data  out  DATA_BITS  head word; valid while empty=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  DEPTH_LOG2+1  words held
- overrun_err  out  1  sticky: word dropped because FIFO full
- frame_err  out  1  sticky: stop bit sampled 0
- parity_err  out  1  sticky: parity mismatch
- break_det  out  1  sticky: break detected (see Optional Feature)
- clear_err  in  1  clears all sticky flags

Behaviour:
- Reset: state WAIT_HIGH, FIFO pointers 0, count=0, empty=1, full=0, all error flags 0. rd_data is don't-care while empty. Reset mid-frame discards the frame in progress.
- Bit timer counts 0..CLK_CYCLES-1.
- Sample point is the cycle at which the timer reaches floor(CLK_CYCLES/2) for the start bit. Every later sample is exactly CLK_CYCLES cycles after the previous one.
- WAIT_HIGH: stay until uart_rx=1, then go to IDLE.
- IDLE: uart_rx=0 -> START, timer cleared.
- START: at the start sample, uart_rx=1 -> IDLE (glitch rejected, no flag). uart_rx=0 -> DATA.
- DATA: DATA_BITS samples, shifted LSB first. Then PARITY if PARITY!=0, else STOP.
- PARITY: sample the parity bit and compare it against the XOR of the data bits (odd: XOR^1).
- STOP, at the stop sample:
  - uart_rx=1 and parity OK: push the word, go to IDLE immediately. Back-to-back frames are supported with no idle gap.
  - uart_rx=1 and parity bad: set parity_err, discard the word, go to IDLE.
  - uart_rx=0: set frame_err, discard the word (parity_err not set), go to WAIT_HIGH.
- Push latency: empty deasserts and count increments on the cycle after the stop sample.
- FIFO:
  - Push when full: word dropped, overrun_err set, contents unchanged.
  - Push and rd_en in the same cycle with count>0: both occur, count unchanged. This includes the full case: the pop frees a slot, so no overrun.
  - rd_en when empty: no effect.
  - Pointers wrap modulo 2**DEPTH_LOG2.
  - full = (count == 2**DEPTH_LOG2).
- clear_err and a new error event in the same cycle: the flag ends set.

Optional Feature:
- Macro UART_RX_BREAK_EN.
- Defined: a frame whose data bits, parity bit (if any) and stop bit all sample 0 sets break_det instead of frame_err. The word is discarded, then the receiver goes to WAIT_HIGH.
- Undefined: break_det is tied 0, and such a frame sets frame_err like any framing error.

Test Plan:
- 8N1, CLK_CYCLES=87, send 0x41 -> one cycle after the stop sample: empty=0, count=1, rd_data=0x41. After pulsing rd_en: empty=1, count=0, no flags.
- uart_rx low for 20 cycles in IDLE -> no push, no flags, next frame 0x5A received correctly.
- DEPTH_LOG2=4, send 17 bytes 0x00..0x10 without reads -> full=1, count=16, overrun_err=1. Reads return 0x00..0x0F in order; 0x10 is lost.
- PARITY=2, send 0x07 with parity bit 0 -> parity_err=1, count=0. clear_err pulse -> parity_err=0. The same byte with parity bit 1 is then received.
- Send 0x55 with stop bit 0, line held low 3 bit times, then high, then 0xA5 -> frame_err=1, only 0xA5 in FIFO. Repeat with clear_err asserted on the error cycle -> frame_err=1.
- Line low 20 bit periods -> with UART_RX_BREAK_EN: break_det=1, frame_err=0; without the macro: frame_err=1, break_det=0. In both cases count=0.
- Assert rst for one cycle mid-data-bit while the line is low -> after reset: count=0 and no push until the line goes high and a new full frame arrives.
